// File: rtl/mac_4_bit.sv
// mac_4_bit: unsigned 4-bit multiply-accumulate.
// Each rising clk edge adds i*j to a 9-bit accumulator. The sum wraps
// modulo 512 and there is no overflow flag. The multiply-add path is
// combinational, so there are no pipeline stages.
//
// Ports:
//   clk  system clock, rising edge
//   rst  asynchronous active-low clear of the accumulator
//   i    4-bit unsigned multiplicand
//   j    4-bit unsigned multiplier
//   f    9-bit accumulator, driven straight from the register
module mac_4_bit (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i,
  input  logic [3:0] j,
  output logic [8:0] f
);

  // Adder cells return {carry, sum}.
  function automatic logic [1:0] ha(input logic a, input logic b);
    return {a & b, a ^ b};
  endfunction

  function automatic logic [1:0] fa(input logic a, input logic b, input logic cin);
    return {(a & b) | (cin & (a ^ b)), a ^ b ^ cin};
  endfunction

  logic [3:0][3:0] pp;
  logic [3:0]      upper;
  logic [3:0]      row_sum;
  logic            mul_carry;
  logic [1:0]      mul_cell;
  logic [7:0]      prod;

  // Array multiplier. Row r adds partial product r to the upper four bits
  // of the running sum. The row's bit 0 is final and becomes prod[r].
  always_comb begin
    pp        = '0;
    upper     = '0;
    row_sum   = '0;
    mul_carry = 1'b0;
    mul_cell  = '0;
    prod      = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        pp[r][c] = i[c] & j[r];
      end
    end
    prod[0] = pp[0][0];
    upper   = {1'b0, pp[0][3:1]};
    for (int r = 1; r < 4; r++) begin
      mul_cell   = ha(upper[0], pp[r][0]);
      row_sum[0] = mul_cell[0];
      mul_carry  = mul_cell[1];
      for (int c = 1; c < 4; c++) begin
        mul_cell   = fa(upper[c], pp[r][c], mul_carry);
        row_sum[c] = mul_cell[0];
        mul_carry  = mul_cell[1];
      end
      prod[r] = row_sum[0];
      upper   = {mul_carry, row_sum[3:1]};
    end
    prod[7:4] = upper;
  end

  logic [8:0] addend;
  logic [8:0] f_next;
  logic       add_carry;
  logic [1:0] add_cell;

  // 9-bit ripple-carry accumulate. The final carry-out is dropped, so the
  // sum wraps modulo 512.
  always_comb begin
    addend    = {1'b0, prod};
    f_next    = '0;
    add_carry = 1'b0;
    add_cell  = '0;
    add_cell  = ha(f[0], addend[0]);
    f_next[0] = add_cell[0];
    add_carry = add_cell[1];
    for (int b = 1; b < 9; b++) begin
      add_cell  = fa(f[b], addend[b], add_carry);
      f_next[b] = add_cell[0];
      add_carry = add_cell[1];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      f <= '0;
    end else begin
      f <= f_next;
    end
  end

endmodule

// File: tb/tb_mac_4_bit.sv
// tb_mac_4_bit: directed self-checking bench for mac_4_bit.
// Operands change one time unit after each rising edge.
// f is sampled one time unit after the edge.
module tb_mac_4_bit;

  logic       clk;
  logic       rst;
  logic [3:0] i;
  logic [3:0] j;
  logic [8:0] f;

  int n_chk  = 0;
  int n_pass = 0;

  mac_4_bit dut (
    .clk(clk),
    .rst(rst),
    .i  (i),
    .j  (j),
    .f  (f)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Present operands, take one rising edge, then check the accumulator.
  task automatic step(input string tag, input logic [3:0] ii, input logic [3:0] jj,
                      input logic [8:0] exp);
    i = ii;
    j = jj;
    @(posedge clk);
    #1;
    check(tag, f, exp);
  endtask

  initial begin
    rst = 1'b0;
    i   = 4'd0;
    j   = 4'd0;

    // The rising edge at t=5 occurs while reset is held.
    #12;
    check("reset_state", f, 9'd0);

    // Release reset mid-cycle, then run basic accumulation.
    rst = 1'b1;
    step("basic_10x10", 4'd10, 4'd10, 9'd100);
    step("basic_13x6",  4'd13, 4'd6,  9'd178);
    step("basic_9x2",   4'd9,  4'd2,  9'd196);
    step("basic_5x4",   4'd5,  4'd4,  9'd216);

    // Assert reset asynchronously mid-cycle and check before any edge.
    #3;
    rst = 1'b0;
    #1;
    check("async_clear", f, 9'd0);
    step("held_9x2", 4'd9, 4'd2, 9'd0);
    step("held_5x4", 4'd5, 4'd4, 9'd0);

    // Restart from zero, then apply zero operands.
    #3;
    rst = 1'b1;
    step("restart_14x2", 4'd14, 4'd2, 9'd28);
    step("restart_9x3",  4'd9,  4'd3, 9'd55);
    step("zero_i",       4'd0,  4'd9, 9'd55);
    step("zero_j",       4'd7,  4'd0, 9'd55);
    #3;
    rst = 1'b0;
    #1;
    check("clear_after_55", f, 9'd0);
    rst = 1'b1;

    // Wrap-around: 225 + 225 + 225 = 675, and 675 mod 512 = 163.
    step("wrap_1", 4'd15, 4'd15, 9'd225);
    step("wrap_2", 4'd15, 4'd15, 9'd450);
    step("wrap_3", 4'd15, 4'd15, 9'd163);

    // Clear, then change operands mid-cycle. Only the values present at the
    // edge count, and f must not follow the operands between edges.
    #1;
    rst = 1'b0;
    #1;
    check("clear_after_wrap", f, 9'd0);
    rst = 1'b1;
    i = 4'd7;
    j = 4'd9;
    #2;
    i = 4'd1;
    j = 4'd15;
    #1;
    check("no_glitch", f, 9'd0);
    #1;
    i = 4'd3;
    j = 4'd4;
    @(posedge clk);
    #1;
    check("midcycle_3x4", f, 9'd12);
    step("midcycle_next", 4'd2, 4'd1, 9'd14);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #5000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "bench timed out");
  end

endmodule
